// File: rtl/timelogger_pkg.sv
// Shared definitions for the clock/time-setting block: mode encoding,
// field widths, field limits and the modulo-increment helpers.
package timelogger_pkg;

   typedef enum logic [1:0] {
      MODE_RUN      = 2'd0,
      MODE_SET_HOUR = 2'd1,
      MODE_SET_MIN  = 2'd2,
      MODE_SET_SEC  = 2'd3
   } mode_e;

   localparam int HOUR_W = 5;
   localparam int MIN_W  = 6;
   localparam int SEC_W  = 6;

   localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;
   localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
   localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;

   function automatic logic [HOUR_W-1:0] inc_hour(input logic [HOUR_W-1:0] val);
      return (val >= HOUR_MAX) ? 5'd0 : val + 5'd1;
   endfunction

   // Minutes and seconds share width and limit, so one helper serves both.
   function automatic logic [5:0] inc_six(input logic [5:0] val, input logic [5:0] max);
      return (val >= max) ? 6'd0 : val + 6'd1;
   endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler producing a one-cycle tick every CLK_HZ enabled cycles;
// holds while disabled and clears synchronously on clr.
module tick_gen #(
   parameter int CLK_HZ = 50_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [CNT_W-1:0] TERM = CNT_W'(CLK_HZ - 1);

   logic [CNT_W-1:0] cnt_r;

   // Prescale counter: clear wins over count, hold when not enabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= '0;
      end else if (clr) begin
         cnt_r <= '0;
      end else if (en) begin
         cnt_r <= (cnt_r == TERM) ? '0 : cnt_r + CNT_W'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign tick = en && !clr && (cnt_r == TERM);

endmodule

// File: rtl/time_set_ctrl.sv
// Time-of-day keeper with a key-driven set mode: key1 cycles modes,
// key2 increments the selected field, key3 pauses/resumes or confirms.
module time_set_ctrl
   import timelogger_pkg::*;
#(
   parameter int CLK_HZ = 50_000_000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              key1_pulse,
   input  logic              key2_pulse,
   input  logic              key3_pulse,
   output logic [HOUR_W-1:0] hour,
   output logic [MIN_W-1:0]  minute,
   output logic [SEC_W-1:0]  second,
   output logic [1:0]        mode,
   output logic              running,
   output logic              sec_tick
);

   mode_e             mode_r, mode_nxt_s;
   logic              paused_r, paused_nxt_s;
   logic [HOUR_W-1:0] hour_r, hour_nxt_s;
   logic [MIN_W-1:0]  min_r, min_nxt_s;
   logic [SEC_W-1:0]  sec_r, sec_nxt_s;
   logic              running_r, running_nxt_s;
   logic              sec_tick_r;
   logic              tick_s;
   logic              clr_s;

   // Prescaler only runs while the registered running flag is set.
   tick_gen #(.CLK_HZ(CLK_HZ)) u_tick_gen (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (running_r),
      .clr   (clr_s),
      .tick  (tick_s)
   );

   // Next-state logic: tick carry chain plus key handling by priority key1 > key3 > key2.
   always_comb begin
      mode_nxt_s   = mode_r;
      paused_nxt_s = paused_r;
      hour_nxt_s   = hour_r;
      min_nxt_s    = min_r;
      sec_nxt_s    = sec_r;

      // Ticks only arrive in RUN, so they never collide with key2 edits.
      if (tick_s) begin
         sec_nxt_s = inc_six(sec_r, SEC_MAX);
         if (sec_r == SEC_MAX) begin
            min_nxt_s = inc_six(min_r, MIN_MAX);
            if (min_r == MIN_MAX) begin
               hour_nxt_s = inc_hour(hour_r);
            end else begin
               hour_nxt_s = hour_r;
            end
         end else begin
            min_nxt_s = min_r;
         end
      end else begin
         sec_nxt_s = sec_r;
      end

      case (mode_r)
         MODE_RUN: begin
            if (key1_pulse) begin
               mode_nxt_s = MODE_SET_HOUR;
            end else if (key3_pulse) begin
               paused_nxt_s = ~paused_r;
            end else begin
               mode_nxt_s = MODE_RUN;
            end
         end
         MODE_SET_HOUR: begin
            if (key1_pulse) begin
               mode_nxt_s = MODE_SET_MIN;
            end else if (key3_pulse) begin
               mode_nxt_s   = MODE_RUN;
               paused_nxt_s = 1'b0;
            end else if (key2_pulse) begin
               hour_nxt_s = inc_hour(hour_r);
            end else begin
               mode_nxt_s = MODE_SET_HOUR;
            end
         end
         MODE_SET_MIN: begin
            if (key1_pulse) begin
               mode_nxt_s = MODE_SET_SEC;
            end else if (key3_pulse) begin
               mode_nxt_s   = MODE_RUN;
               paused_nxt_s = 1'b0;
            end else if (key2_pulse) begin
               min_nxt_s = inc_six(min_r, MIN_MAX);
            end else begin
               mode_nxt_s = MODE_SET_MIN;
            end
         end
         MODE_SET_SEC: begin
            if (key1_pulse) begin
               mode_nxt_s = MODE_RUN;
            end else if (key3_pulse) begin
               mode_nxt_s   = MODE_RUN;
               paused_nxt_s = 1'b0;
            end else if (key2_pulse) begin
               sec_nxt_s = inc_six(sec_r, SEC_MAX);
            end else begin
               mode_nxt_s = MODE_SET_SEC;
            end
         end
         default: begin
            mode_nxt_s   = MODE_RUN;
            paused_nxt_s = 1'b0;
         end
      endcase

      running_nxt_s = (mode_nxt_s == MODE_RUN) && !paused_nxt_s;
   end

   // Returning to RUN from any set mode restarts the second from zero.
   assign clr_s = (mode_r != MODE_RUN) && (mode_nxt_s == MODE_RUN);

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_r     <= MODE_RUN;
         paused_r   <= 1'b0;
         hour_r     <= 5'd0;
         min_r      <= 6'd0;
         sec_r      <= 6'd0;
         running_r  <= 1'b1;
         sec_tick_r <= 1'b0;
      end else begin
         mode_r     <= mode_nxt_s;
         paused_r   <= paused_nxt_s;
         hour_r     <= hour_nxt_s;
         min_r      <= min_nxt_s;
         sec_r      <= sec_nxt_s;
         running_r  <= running_nxt_s;
         sec_tick_r <= tick_s;
      end
   end

   assign hour     = hour_r;
   assign minute   = min_r;
   assign second   = sec_r;
   assign mode     = mode_r;
   assign running  = running_r;
   assign sec_tick = sec_tick_r;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed self-checking bench for time_set_ctrl with a 10-cycle second.
module tb_time_set_ctrl;

   logic       clk;
   logic       rst_n;
   logic       key1_pulse;
   logic       key2_pulse;
   logic       key3_pulse;
   logic [4:0] hour;
   logic [5:0] minute;
   logic [5:0] second;
   logic [1:0] mode;
   logic       running;
   logic       sec_tick;

   int n_total = 0;
   int n_bad   = 0;
   int tick_cnt;

   time_set_ctrl #(.CLK_HZ(10)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .key1_pulse (key1_pulse),
      .key2_pulse (key2_pulse),
      .key3_pulse (key3_pulse),
      .hour       (hour),
      .minute     (minute),
      .second     (second),
      .mode       (mode),
      .running    (running),
      .sec_tick   (sec_tick)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   // Called at a negedge; keys are seen by exactly one rising edge.
   task automatic pulse(input logic k1, input logic k2, input logic k3);
      key1_pulse = k1;
      key2_pulse = k2;
      key3_pulse = k3;
      @(negedge clk);
      key1_pulse = 1'b0;
      key2_pulse = 1'b0;
      key3_pulse = 1'b0;
   endtask

   task automatic pulse_n(input int n, input logic k1, input logic k2, input logic k3);
      for (int i = 0; i < n; i++) pulse(k1, k2, k3);
   endtask

   initial begin
      rst_n = 1'b0;
      key1_pulse = 1'b0;
      key2_pulse = 1'b0;
      key3_pulse = 1'b0;
      repeat (2) @(negedge clk);

      check("rst_hour", hour, 0);
      check("rst_minute", minute, 0);
      check("rst_second", second, 0);
      check("rst_mode", mode, 0);
      check("rst_running", running, 1);
      check("rst_sec_tick", sec_tick, 0);

      // Release; next rising edge is cycle 1.
      rst_n = 1'b1;
      repeat (9) @(negedge clk);
      check("c9_sec_tick", sec_tick, 0);
      check("c9_second", second, 0);
      @(negedge clk);
      check("c10_sec_tick", sec_tick, 1);
      check("c10_second", second, 1);
      @(negedge clk);
      check("c11_sec_tick", sec_tick, 0);
      repeat (9) @(negedge clk);
      check("c20_sec_tick", sec_tick, 1);
      check("c20_second", second, 2);
      repeat (10) @(negedge clk);
      check("c30_sec_tick", sec_tick, 1);
      check("c30_second", second, 3);
      repeat (5) @(negedge clk);
      check("c35_second", second, 3);
      check("c35_running", running, 1);

      // All three keys together in RUN: only key1 acts.
      pulse(1'b1, 1'b1, 1'b1);
      check("allkeys_mode", mode, 1);
      check("allkeys_second", second, 3);
      check("allkeys_minute", minute, 0);
      check("allkeys_hour", hour, 0);
      check("allkeys_running", running, 0);

      // 25 hour increments wrap 23->0 once.
      pulse_n(25, 1'b0, 1'b1, 1'b0);
      check("hset_mode", mode, 1);
      check("hset_hour", hour, 1);
      check("hset_minute", minute, 0);
      check("hset_second", second, 3);

      // Preload 23:59:59.
      pulse_n(22, 1'b0, 1'b1, 1'b0);
      pulse(1'b1, 1'b0, 1'b0);
      pulse_n(59, 1'b0, 1'b1, 1'b0);
      pulse(1'b1, 1'b0, 1'b0);
      pulse_n(56, 1'b0, 1'b1, 1'b0);
      check("pre_mode", mode, 3);
      check("pre_hour", hour, 23);
      check("pre_minute", minute, 59);
      check("pre_second", second, 59);

      pulse(1'b0, 1'b0, 1'b1);
      check("confirm_mode", mode, 0);
      check("confirm_running", running, 1);
      tick_cnt = 0;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         tick_cnt += int'(sec_tick);
      end
      check("roll_pre_second", second, 59);
      @(negedge clk);
      tick_cnt += int'(sec_tick);
      check("roll_hour", hour, 0);
      check("roll_minute", minute, 0);
      check("roll_second", second, 0);
      check("roll_ticks", tick_cnt, 1);

      // Pause at second=2.
      repeat (20) @(negedge clk);
      check("pz_second", second, 2);
      pulse(1'b0, 1'b0, 1'b1);
      check("pz_running", running, 0);
      repeat (50) @(negedge clk);
      check("pz_hold_second", second, 2);
      check("pz_hold_running", running, 0);
      pulse(1'b0, 1'b0, 1'b1);
      check("resume_running", running, 1);
      repeat (8) @(negedge clk);
      check("resume_pre_second", second, 2);
      @(negedge clk);
      check("resume_second", second, 3);
      check("resume_sec_tick", sec_tick, 1);

      // key2 in RUN is ignored.
      pulse(1'b0, 1'b1, 1'b0);
      check("run_key2_second", second, 3);
      check("run_key2_hour", hour, 0);
      check("run_key2_minute", minute, 0);

      // key1 coincident with a tick: both take effect.
      repeat (8) @(negedge clk);
      pulse(1'b1, 1'b0, 1'b0);
      check("tick_key1_mode", mode, 1);
      check("tick_key1_second", second, 4);
      check("tick_key1_sec_tick", sec_tick, 1);

      // Into SET_MIN, bump minute, then async reset mid-cycle.
      pulse(1'b1, 1'b0, 1'b0);
      pulse(1'b0, 1'b1, 1'b0);
      check("smin_mode", mode, 2);
      check("smin_minute", minute, 1);
      check("smin_second", second, 4);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_mode", mode, 0);
      check("arst_minute", minute, 0);
      check("arst_second", second, 0);
      check("arst_hour", hour, 0);
      check("arst_running", running, 1);
      check("arst_sec_tick", sec_tick, 0);

      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/time_set_ctrl.md
TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000: clk frequency in Hz; sets the 1 Hz tick period.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 key1_pulse  input  1  one-cycle mode-select pulse from the key debounce stage.
REQ-005 key2_pulse  input  1  one-cycle increment pulse.
REQ-006 key3_pulse  input  1  one-cycle start/stop or confirm pulse.
REQ-007 hour  output  5  current hours, 0..23.
REQ-008 minute  output  6  current minutes, 0..59.
REQ-009 second  output  6  current seconds, 0..59.
REQ-010 mode  output  2  encoded FSM state: 0=RUN, 1=SET_HOUR, 2=SET_MIN, 3=SET_SEC.
REQ-011 running  output  1  high when time is advancing (mode RUN and not paused).
REQ-012 sec_tick  output  1  one-cycle pulse on every seconds increment caused by the tick.

Function
REQ-013 Prescaler shall count 0..CLK_HZ-1 only while running=1, and shall assert an internal tick in the cycle it holds CLK_HZ-1, then wrap to 0.
REQ-014 Prescaler shall hold its value while paused, and shall clear to 0 on every exit from a SET_* state into RUN.
REQ-015 On tick: second increments; 59->0 carries to minute; minute 59->0 carries to hour; hour 23->0; 23:59:59 -> 00:00:00 in one cycle.
REQ-016 sec_tick shall be registered and asserted in the same cycle the new second value appears on the outputs.
REQ-017 FSM transitions on key1_pulse: RUN->SET_HOUR->SET_MIN->SET_SEC->RUN.
REQ-018 key2_pulse in SET_HOUR/SET_MIN/SET_SEC shall increment only the selected field, modulo 24/60/60, with no carry into other fields.
REQ-019 key2_pulse in RUN shall be ignored.
REQ-020 key3_pulse in RUN shall toggle the internal paused flag.
REQ-021 key3_pulse in any SET_* state shall return the FSM to RUN and clear paused.
REQ-022 Key priority within one cycle is key1 > key3 > key2; lower-priority pulses in the same cycle are discarded.
REQ-023 Tick coincident with key1_pulse in RUN: the time advance and the transition to SET_HOUR both take effect.
REQ-024 No tick shall occur in SET_* states; time fields change there only via key2_pulse.
REQ-025 All outputs shall be registered; key pulse to field/mode update latency is 1 clk.

Reset
REQ-026 While rst_n=0: hour=0, minute=0, second=0, mode=RUN, paused=0, running=1, sec_tick=0, prescaler=0.
REQ-027 Assertion of rst_n mid-operation, including in a SET_* state, shall take effect immediately with no clk edge required.
REQ-028 After deassertion, the first tick shall occur CLK_HZ cycles later.

Structure
REQ-029 Package timelogger_pkg shall hold the mode state encoding, the field widths (5/6/6), and the constants HOUR_MAX=23, MIN_MAX=59, SEC_MAX=59.
REQ-030 The prescaler shall be a sub-module tick_gen with ports clk, rst_n, en, clr, tick, parameterised by CLK_HZ.
REQ-031 Implementation size shall be roughly 150-250 lines of RTL total.

Verification (CLK_HZ=10 in simulation)
REQ-032 Release reset, run 35 clk -> second=3 at cycle 30; sec_tick pulses at cycles 10, 20, 30; running=1.
REQ-033 Preload 23:59:59 via set mode, return to RUN, wait 10 clk -> 00:00:00 with a single sec_tick.
REQ-034 key1 once, then key2 x25 -> mode=1, hour=1; minute and second unchanged.
REQ-035 key3 in RUN at second=2, wait 50 clk -> second stays 2, running=0; key3 again -> running=1 and counting resumes.
REQ-036 key1, key2 and key3 pulsed in the same cycle in RUN -> mode=1, paused unchanged, no field change.
REQ-037 Drop rst_n asynchronously mid-cycle while in SET_MIN -> all outputs at reset values before the next clk edge.
